// File: rtl/pixel_pkg.sv
// Shared constants for the SPI pixel framer: writer state encoding,
// header flag position, legal pixel sizes and an index-width helper.
package pixel_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_PEND = 2'd3;

  localparam int SHOW_BIT = 7;

  localparam int BPP_RGB  = 3;
  localparam int BPP_RGBW = 4;

  // Index width that stays at least one bit wide for a single-LED strip.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_pixel_framer_if.sv
// Bus between the SPI receiver / NeoPixel driver side and the framer.
// Handshakes: rx_valid_i is a one-cycle strobe with no back-pressure, every
// strobe qualifies rx_data_i; drv_req_i asks for drv_addr_i and the pixel
// appears on drv_pixel_o the next cycle, held until the next request;
// drv_start_o is a one-cycle pulse issued only while drv_busy_i is low.
interface spi_pixel_framer_if
  import pixel_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int BPP      = 3
);
  localparam int AW = idx_width(NUM_LEDS);
  localparam int CW = $clog2(NUM_LEDS + 1);
  localparam int PW = 8 * BPP;

  logic          frame_start_i;
  logic          frame_end_i;
  logic [7:0]    rx_data_i;
  logic          rx_valid_i;
  logic          drv_start_o;
  logic          drv_busy_i;
  logic          drv_req_i;
  logic [AW-1:0] drv_addr_i;
  logic [PW-1:0] drv_pixel_o;
  logic [CW-1:0] drv_count_o;
  logic          overflow_o;
  logic          reject_o;
  logic [1:0]    dbg_state;

  modport master (
    output frame_start_i, frame_end_i, rx_data_i, rx_valid_i,
           drv_busy_i, drv_req_i, drv_addr_i,
    input  drv_start_o, drv_pixel_o, drv_count_o, overflow_o, reject_o,
           dbg_state
  );

  modport slave (
    input  frame_start_i, frame_end_i, rx_data_i, rx_valid_i,
           drv_busy_i, drv_req_i, drv_addr_i,
    output drv_start_o, drv_pixel_o, drv_count_o, overflow_o, reject_o,
           dbg_state
  );

endinterface

// File: rtl/pixel_bank_ram.sv
// Two-bank pixel store: one write port for the assembler, one registered
// read port for the driver. Address is {bank, index} with the index padded
// to a power of two so any LED count maps cleanly.
module pixel_bank_ram #(
  parameter int AW = 3,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW:0]   raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(2**(AW+1))-1];

  // Store a completed pixel.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read that holds its value between requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/spi_pixel_framer.sv
// Assembles SPI bytes into RGB/RGBW pixels, writes them into the hidden
// bank and hands complete frames to the NeoPixel driver via a bank swap.
module spi_pixel_framer
  import pixel_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int BPP      = 3
) (
  input logic               clk_i,
  input logic               reset_i,
  spi_pixel_framer_if.slave bus
);

  localparam int AW = idx_width(NUM_LEDS);
  localparam int CW = $clog2(NUM_LEDS + 1);
  localparam int PW = 8 * BPP;

  generate
    if (BPP != BPP_RGB && BPP != BPP_RGBW) begin : g_bad_bpp
      $error("spi_pixel_framer: BPP must be 3 or 4");
    end
  endgenerate

  logic [1:0]    state;
  logic          wbank;
  logic          dbank;
  logic [CW-1:0] pix;
  logic [1:0]    slot;
  logic [PW-1:0] asm_q;
  logic          show;
  logic          overflow;
  logic          reject;
  logic          drv_start;
  logic [CW-1:0] drv_count;

  logic          byte_take;
  logic          byte_drop;
  logic          pix_done;
  logic [PW-1:0] asm_next;
  logic [CW-1:0] pix_next;

  // Classify the incoming byte and build the pixel it would complete.
  always_comb begin
    byte_take = (state == ST_DATA) && bus.rx_valid_i && !bus.frame_start_i &&
                (pix < CW'(NUM_LEDS));
    byte_drop = (state == ST_DATA) && bus.rx_valid_i && !bus.frame_start_i &&
                (pix >= CW'(NUM_LEDS));
    pix_done  = byte_take && (slot == 2'(BPP - 1));
    asm_next  = asm_q;
    for (int k = 0; k < BPP; k++) begin
      if (slot == 2'(k)) asm_next[8*(BPP-1-k) +: 8] = bus.rx_data_i;
    end
    pix_next  = pix_done ? pix + CW'(1) : pix;
  end

  // Writer FSM: header, byte assembly, frame end and deferred swap.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= ST_IDLE;
      wbank     <= 1'b0;
      dbank     <= 1'b1;
      pix       <= '0;
      slot      <= '0;
      asm_q     <= '0;
      show      <= 1'b0;
      overflow  <= 1'b0;
      reject    <= 1'b0;
      drv_start <= 1'b0;
      drv_count <= '0;
    end else begin
      drv_start <= 1'b0;
      reject    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.frame_start_i) begin
            state    <= ST_HDR;
            pix      <= '0;
            slot     <= '0;
            overflow <= 1'b0;
            show     <= 1'b0;
          end
        end
        ST_HDR, ST_DATA: begin
          if (bus.frame_start_i) begin
            // Abandon the partial frame and wait for a fresh header.
            state    <= ST_HDR;
            pix      <= '0;
            slot     <= '0;
            overflow <= 1'b0;
            show     <= 1'b0;
          end else begin
            if (state == ST_HDR && bus.rx_valid_i) begin
              show  <= bus.rx_data_i[SHOW_BIT];
              state <= ST_DATA;
            end
            if (byte_take) begin
              asm_q <= asm_next;
              slot  <= pix_done ? 2'd0 : slot + 2'd1;
              pix   <= pix_next;
            end
            if (byte_drop) overflow <= 1'b1;
            // The same-cycle byte is already folded into pix_next.
            if (bus.frame_end_i) begin
              slot <= '0;
              if (show && pix_next != '0) begin
                if (!bus.drv_busy_i) begin
                  wbank     <= ~wbank;
                  dbank     <= wbank;
                  drv_count <= pix_next;
                  drv_start <= 1'b1;
                  state     <= ST_IDLE;
                end else begin
                  state <= ST_PEND;
                end
              end else begin
                state <= ST_IDLE;
              end
            end
          end
        end
        default: begin
          if (bus.frame_start_i) reject <= 1'b1;
          if (!bus.drv_busy_i) begin
            wbank     <= ~wbank;
            dbank     <= wbank;
            drv_count <= pix;
            drv_start <= 1'b1;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  pixel_bank_ram #(.AW(AW), .DW(PW)) u_ram (
    .clk   (clk_i),
    .rst   (reset_i),
    .we    (pix_done),
    .waddr ({wbank, pix[AW-1:0]}),
    .wdata (asm_next),
    .re    (bus.drv_req_i),
    .raddr ({dbank, bus.drv_addr_i}),
    .rdata (bus.drv_pixel_o)
  );

  assign bus.drv_start_o = drv_start;
  assign bus.drv_count_o = drv_count;
  assign bus.overflow_o  = overflow;
  assign bus.reject_o    = reject;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_spi_pixel_framer.sv
// Bench for spi_pixel_framer: an 8x RGB instance (a) and a 5x RGBW
// instance (b) share stimulus, gated by sel. Pixel reads go through an
// expected-value queue checked one cycle after each request.
module tb_spi_pixel_framer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       sel;
  logic       frame_start, frame_end, rx_valid, drv_busy, drv_req;
  logic [7:0] rx_data;
  logic [2:0] drv_addr;

  spi_pixel_framer_if #(.NUM_LEDS(8), .BPP(3)) bus_a ();
  spi_pixel_framer_if #(.NUM_LEDS(5), .BPP(4)) bus_b ();

  assign bus_a.frame_start_i = frame_start & ~sel;
  assign bus_a.frame_end_i   = frame_end & ~sel;
  assign bus_a.rx_valid_i    = rx_valid & ~sel;
  assign bus_a.rx_data_i     = rx_data;
  assign bus_a.drv_busy_i    = drv_busy;
  assign bus_a.drv_req_i     = drv_req & ~sel;
  assign bus_a.drv_addr_i    = drv_addr;

  assign bus_b.frame_start_i = frame_start & sel;
  assign bus_b.frame_end_i   = frame_end & sel;
  assign bus_b.rx_valid_i    = rx_valid & sel;
  assign bus_b.rx_data_i     = rx_data;
  assign bus_b.drv_busy_i    = drv_busy;
  assign bus_b.drv_req_i     = drv_req & sel;
  assign bus_b.drv_addr_i    = drv_addr;

  spi_pixel_framer #(.NUM_LEDS(8), .BPP(3)) dut_a (
    .clk_i(clk), .reset_i(rst), .bus(bus_a));
  spi_pixel_framer #(.NUM_LEDS(5), .BPP(4)) dut_b (
    .clk_i(clk), .reset_i(rst), .bus(bus_b));

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic        rd_pend = 1'b0;
  logic        rd_sel  = 1'b0;
  logic [31:0] mon_act;

  always @(posedge clk) begin
    rd_pend <= drv_req;
    rd_sel  <= sel;
  end

  always @(negedge clk) begin
    if (rd_pend) begin
      mon_act = rd_sel ? bus_b.drv_pixel_o : {8'h00, bus_a.drv_pixel_o};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL read_pixel: got 0x%0h with no expected entry", mon_act);
      end else begin
        check("read_pixel", mon_act, exp_q.pop_front());
      end
    end
  end

  // ---------------- read vector table ----------------
  typedef struct {
    logic        sel;
    logic [2:0]  addr;
    logic [31:0] pix;
  } rd_vec_t;

  rd_vec_t rd_tab [0:11];

  // ---------------- driver tasks (entered just after a negedge) ----------
  task automatic pulse_start();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pulse_end();
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input int n,
                            input logic [7:0] first);
    pulse_start();
    send_byte(hdr);
    for (int k = 0; k < n; k++) send_byte(first + 8'(k));
  endtask

  task automatic do_reads(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      sel      = rd_tab[i].sel;
      drv_addr = rd_tab[i].addr;
      drv_req  = 1'b1;
      exp_q.push_back(rd_tab[i].pix);
      @(negedge clk);
    end
    drv_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic full_frame_a(input string tag);
    sel = 1'b0;
    send_frame(8'h80, 24, 8'h01);
    pulse_end();
    check({tag, "_start"}, 32'(bus_a.drv_start_o), 32'd1);
    check({tag, "_count"}, 32'(bus_a.drv_count_o), 32'd8);
    check({tag, "_overflow"}, 32'(bus_a.overflow_o), 32'd0);
    @(negedge clk);
    check({tag, "_start_pulse"}, 32'(bus_a.drv_start_o), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rd_tab[0]  = '{1'b0, 3'd0, 32'h00010203};
    rd_tab[1]  = '{1'b0, 3'd7, 32'h00161718};
    rd_tab[2]  = '{1'b0, 3'd3, 32'h000a0b0c};
    rd_tab[3]  = '{1'b0, 3'd0, 32'h00010203};
    rd_tab[4]  = '{1'b0, 3'd0, 32'h00414243};
    rd_tab[5]  = '{1'b0, 3'd1, 32'h00444546};
    rd_tab[6]  = '{1'b0, 3'd0, 32'h00515253};
    rd_tab[7]  = '{1'b0, 3'd1, 32'h00040506};
    rd_tab[8]  = '{1'b1, 3'd4, 32'h11121314};
    rd_tab[9]  = '{1'b1, 3'd0, 32'h01020304};
    rd_tab[10] = '{1'b0, 3'd0, 32'h00010203};
    rd_tab[11] = '{1'b0, 3'd7, 32'h00161718};

    rst = 1'b1;
    sel = 1'b0;
    frame_start = 1'b0; frame_end = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    drv_busy = 1'b0; drv_req = 1'b0; drv_addr = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_start",    32'(bus_a.drv_start_o), 32'd0);
    check("rst_pixel",    32'(bus_a.drv_pixel_o), 32'd0);
    check("rst_count",    32'(bus_a.drv_count_o), 32'd0);
    check("rst_overflow", 32'(bus_a.overflow_o),  32'd0);
    check("rst_reject",   32'(bus_a.reject_o),    32'd0);
    check("rst_state",    32'(bus_a.dbg_state),   32'd0);
    check("rst_b_count",  32'(bus_b.drv_count_o), 32'd0);

    // Frame end while idle does nothing.
    pulse_end();
    check("idle_end_start", 32'(bus_a.drv_start_o), 32'd0);

    // Full RGB frame.
    full_frame_a("full");
    do_reads(0, 2);
    @(negedge clk);
    check("pixel_hold", 32'(bus_a.drv_pixel_o), 32'h000a0b0c);

    // No-show header: no swap, old bank still displayed.
    send_frame(8'h00, 6, 8'h31);
    pulse_end();
    check("noshow_start", 32'(bus_a.drv_start_o), 32'd0);
    check("noshow_count", 32'(bus_a.drv_count_o), 32'd8);
    do_reads(3, 3);

    // Partial trailing byte discarded.
    send_frame(8'h80, 7, 8'h41);
    pulse_end();
    check("partial_start", 32'(bus_a.drv_start_o), 32'd1);
    check("partial_count", 32'(bus_a.drv_count_o), 32'd2);
    do_reads(4, 5);

    // Busy driver: pending swap, rejected frame, deferred start.
    drv_busy = 1'b1;
    send_frame(8'h80, 3, 8'h51);
    pulse_end();
    check("pend_no_start", 32'(bus_a.drv_start_o), 32'd0);
    check("pend_state",    32'(bus_a.dbg_state),   32'd3);
    check("pend_no_reject", 32'(bus_a.reject_o),   32'd0);
    pulse_start();
    check("reject_pulse", 32'(bus_a.reject_o), 32'd1);
    send_byte(8'h80);
    check("reject_one_cycle", 32'(bus_a.reject_o), 32'd0);
    for (int k = 0; k < 6; k++) send_byte(8'h61 + 8'(k));
    pulse_end();
    check("pend_still_no_start", 32'(bus_a.drv_start_o), 32'd0);
    check("pend_count_held",     32'(bus_a.drv_count_o), 32'd2);
    drv_busy = 1'b0;
    @(negedge clk);
    check("deferred_start", 32'(bus_a.drv_start_o), 32'd1);
    check("deferred_count", 32'(bus_a.drv_count_o), 32'd1);
    @(negedge clk);
    check("deferred_pulse", 32'(bus_a.drv_start_o), 32'd0);
    check("deferred_idle",  32'(bus_a.dbg_state),   32'd0);
    do_reads(6, 7);

    // RGBW with overflow on the 5-LED instance.
    sel = 1'b1;
    send_frame(8'h80, 20, 8'h01);
    check("b_no_overflow_yet", 32'(bus_b.overflow_o), 32'd0);
    send_byte(8'h15);
    check("b_overflow_rise", 32'(bus_b.overflow_o), 32'd1);
    send_byte(8'h16);
    pulse_end();
    check("b_start",    32'(bus_b.drv_start_o), 32'd1);
    check("b_count",    32'(bus_b.drv_count_o), 32'd5);
    check("b_overflow", 32'(bus_b.overflow_o),  32'd1);
    check("a_quiet",    32'(bus_a.drv_start_o), 32'd0);
    do_reads(8, 9);

    // Asynchronous reset mid-frame.
    sel = 1'b0;
    send_frame(8'h80, 4, 8'h71);
    #2 rst = 1'b1;
    #1;
    check("arst_start",    32'(bus_a.drv_start_o), 32'd0);
    check("arst_pixel",    32'(bus_a.drv_pixel_o), 32'd0);
    check("arst_count",    32'(bus_a.drv_count_o), 32'd0);
    check("arst_overflow", 32'(bus_a.overflow_o),  32'd0);
    check("arst_state",    32'(bus_a.dbg_state),   32'd0);
    check("arst_b_count",  32'(bus_b.drv_count_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    full_frame_a("after_rst");
    do_reads(10, 11);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL read_queue_drain: got %0d left expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
